// File: rtl/logic_unit_pkg.sv
// Shared encodings for the serial logic unit: operation select and FSM state.
package logic_unit_pkg;

  typedef enum logic [1:0] {
    OP_NOT = 2'b00,
    OP_AND = 2'b01,
    OP_OR  = 2'b10,
    OP_XOR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/logic_slice.sv
// Combinational SLICE-bit bitwise operation; b_i is ignored for NOT.
module logic_slice
  import logic_unit_pkg::*;
#(
  parameter int SLICE = 2
) (
  input  op_e              op_i,
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  output logic [SLICE-1:0] y_o
);

  always_comb begin
    y_o = '0;
    unique case (op_i)
      OP_NOT: y_o = ~a_i;
      OP_AND: y_o = a_i & b_i;
      OP_OR:  y_o = a_i | b_i;
      OP_XOR: y_o = a_i ^ b_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_serial.sv
// Multi-cycle WIDTH-bit logic unit, SLICE bits per clock, LSB slice first.
// Define LOGIC_FLAGS_EN to add the registered zero flag output.
//
// state | meaning
// IDLE  | waiting for start
// BUSY  | processing one slice per clock
// DONE  | one-cycle done pulse; start here is accepted back-to-back
module logic_unit_serial
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
`ifdef LOGIC_FLAGS_EN
  output logic             zero_o,
`endif
  output logic [WIDTH-1:0] result_o
);

  localparam int N     = WIDTH / SLICE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
    $error("logic_unit_serial: WIDTH must be a non-zero multiple of SLICE");
  end

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  op_e              op_q;
  logic [WIDTH-1:0] a_q, b_q, work_q, work_d, result_q;
  logic             busy_q, done_q;
  logic [SLICE-1:0] slice_y;

  logic_slice #(.SLICE(SLICE)) u_slice (
    .op_i (op_q),
    .a_i  (a_q[SLICE-1:0]),
    .b_i  (b_q[SLICE-1:0]),
    .y_o  (slice_y)
  );

  // New slice enters at the MSB end, so after N shifts slice 0 sits at the LSB.
  always_comb begin
    work_d = (work_q >> SLICE) | (WIDTH'(slice_y) << (WIDTH - SLICE));
  end

`ifdef LOGIC_FLAGS_EN
  logic zero_q;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_NOT;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef LOGIC_FLAGS_EN
      zero_q   <= 1'b1;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            op_q    <= op_e'(op_i);
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_BUSY;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          a_q    <= a_q >> SLICE;
          b_q    <= b_q >> SLICE;
          work_q <= work_d;
          if (cnt_q == LAST) begin
            result_q <= work_d;
`ifdef LOGIC_FLAGS_EN
            zero_q   <= (work_d == '0);
`endif
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
`ifdef LOGIC_FLAGS_EN
  assign zero_o   = zero_q;
`endif

endmodule

// File: tb/tb_logic_unit_serial.sv
// Bench for logic_unit_serial: whole-word reference model plus directed vectors.
module tb_logic_unit_serial;

  localparam int WIDTH = 8;
  localparam int SLICE = 2;
  localparam int N     = WIDTH / SLICE;

  logic             clk_i = 1'b0;
  logic             reset_i = 1'b1;
  logic             start_i = 1'b0;
  logic [1:0]       op_i = 2'b00;
  logic [WIDTH-1:0] a_i = '0;
  logic [WIDTH-1:0] b_i = '0;
  logic             busy_o, done_o;
  logic [WIDTH-1:0] result_o;
`ifdef LOGIC_FLAGS_EN
  logic             zero_o;
`endif

  logic_unit_serial #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
`ifdef LOGIC_FLAGS_EN
    .zero_o   (zero_o),
`endif
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] golden(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      2'b00:   return ~a;
      2'b01:   return a & b;
      2'b10:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // Reference: an accepted request finishes exactly N edges later with the whole-word answer.
  int               m_rem = 0;
  logic             m_done = 1'b0;
  logic [WIDTH-1:0] m_result = '0;
  logic [1:0]       m_op;
  logic [WIDTH-1:0] m_a, m_b;

  always @(posedge clk_i) begin
    if (reset_i) begin
      m_rem = 0; m_done = 1'b0; m_result = '0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_result = golden(m_op, m_a, m_b);
        m_done   = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (start_i) begin
        m_op = op_i; m_a = a_i; m_b = b_i;
        m_rem = N;
      end
    end
  end

  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("busy", busy_o, (m_rem > 0));
      chk("done", done_o, m_done);
      chk("result", result_o, m_result);
`ifdef LOGIC_FLAGS_EN
      chk("zero", zero_o, (m_result == '0));
`endif
      chk("busy_and_done", busy_o & done_o, 1'b0);
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp, input bit exp_zero);
    int cyc;
    @(negedge clk_i);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(negedge clk_i);
    start_i = 1'b0;
    cyc = 0;
    while (!done_o && cyc < 20) begin
      @(negedge clk_i);
      cyc++;
    end
    chk("latency", cyc, N);
    chk("lit_result", result_o, exp);
`ifdef LOGIC_FLAGS_EN
    chk("lit_zero", zero_o, exp_zero);
`else
    if (exp_zero) chk("lit_zero_result", result_o, '0);
`endif
  endtask

  initial begin
    int dones;
    int t_done[$];
    int cyc;
    logic [WIDTH-1:0] captured;

    repeat (2) @(negedge clk_i);
    chk_en = 1'b1;
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_result", result_o, 8'h00);
`ifdef LOGIC_FLAGS_EN
    chk("rst_zero", zero_o, 1'b1);
`endif
    reset_i = 1'b0;

    run_op(2'b00, 8'b1111_1111, 8'h00, 8'b0000_0000, 1'b1);
    run_op(2'b00, 8'b0000_0000, 8'h5A, 8'b1111_1111, 1'b0);
    run_op(2'b00, 8'b1001_1001, 8'h00, 8'b0110_0110, 1'b0);
    run_op(2'b00, 8'b1111_0000, 8'hFF, 8'b0000_1111, 1'b0);
    run_op(2'b01, 8'b1100_1010, 8'b1010_0110, 8'b1000_0010, 1'b0);
    run_op(2'b10, 8'b1100_1010, 8'b1010_0110, 8'b1110_1110, 1'b0);
    run_op(2'b11, 8'b1100_1010, 8'b1010_0110, 8'b0110_1100, 1'b0);

    // Inputs disturbed and start re-pulsed while busy.
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b01; a_i = 8'b1100_1010; b_i = 8'b1010_0110;
    @(negedge clk_i);
    start_i = 1'b0; op_i = 2'b10; a_i = 8'hFF; b_i = 8'hFF;
    dones = 0; captured = '0;
    for (int i = 0; i < 12; i++) begin
      if (i == 1) start_i = 1'b1;
      if (i == 2) start_i = 1'b0;
      @(negedge clk_i);
      if (done_o) begin
        dones++;
        captured = result_o;
      end
    end
    chk("inflight_dones", dones, 1);
    chk("inflight_result", captured, 8'b1000_0010);

    // Start held high: three back-to-back operations.
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b11; a_i = 8'h0F; b_i = 8'hFF;
    cyc = 0;
    while (t_done.size() < 3 && cyc < 40) begin
      @(negedge clk_i);
      cyc++;
      if (done_o) begin
        t_done.push_back(cyc);
        chk("b2b_result", result_o, 8'hF0);
      end
    end
    start_i = 1'b0;
    chk("b2b_count", t_done.size(), 3);
    if (t_done.size() == 3) begin
      chk("b2b_gap1", t_done[1] - t_done[0], N + 1);
      chk("b2b_gap2", t_done[2] - t_done[1], N + 1);
    end
    repeat (3) @(negedge clk_i);

    // Reset on the second BUSY cycle abandons the operation.
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b00; a_i = 8'h00; b_i = 8'h00;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b1;
    @(negedge clk_i);
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_done", done_o, 1'b0);
    chk("midrst_result", result_o, 8'h00);
    reset_i = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (done_o) dones++;
    end
    chk("midrst_no_done", dones, 0);
    run_op(2'b10, 8'b0101_0000, 8'b0000_0011, 8'b0101_0011, 1'b0);

    repeat (2) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/logic_unit_serial.md
# logic_unit_serial

Parametrised, multi-cycle bitwise logic unit that extends the team's 8-bit structural NOT block to WIDTH-bit operands and four operations (NOT, AND, OR, XOR). Operands are latched on a start pulse and processed SLICE bits per clock, LSB slice first, under a small FSM with a busy/done handshake. It sits beside the adder in the ALU datapath as the logic-operation path.

## Interface
- WIDTH, 8, operand/result width in bits; must be a multiple of SLICE.
- SLICE, 2, bits processed per clock; N = WIDTH/SLICE cycles per operation.
- clk  input  1  rising-edge clock; the block has one clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- op  input  2  operation select: 00 NOT A, 01 A AND B, 10 A OR B, 11 A XOR B.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; ignored for NOT.
- busy  output  1  high while slices are being processed.
- done  output  1  one-cycle pulse; result is valid from this cycle on.
- result  output  WIDTH  last completed result; held until the next start is accepted.
- zero  output  1  (only with LOGIC_FLAGS_EN) result == 0; valid alongside result.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: start=1 → latch a, b, op into internal shift registers, clear slice counter, go BUSY. start=0 → stay.
- BUSY: each cycle apply op to the low SLICE bits of the latched operands, shift operands right by SLICE, shift the computed slice into the working result from the MSB end; counter increments. When counter reaches N-1 the final slice is written, the working result is copied to result, and the FSM goes to DONE.
- DONE: done=1 for exactly one cycle. start=1 here is accepted (back-to-back, same as IDLE → BUSY); otherwise go IDLE.
- start in BUSY is ignored; inputs a, b, op may change freely after acceptance without affecting the operation in flight.
- result changes only on the cycle DONE is entered; the working register is internal.
- op values are fully decoded; no illegal op exists.
- Reset (any state, including mid-operation): FSM → IDLE, counter → 0, busy=0, done=0, result=0, zero=1 (if enabled). The operation in flight is abandoned and never signals done.

## Timing
- start sampled high at edge T0 → busy=1 after T0 through edge T0+N; state DONE, done=1, and new result visible after edge T0+N (latency N cycles, 4 for defaults).
- busy and done are never high together.
- Back-to-back: start held high continuously yields one done per N+1 cycles.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- LOGIC_FLAGS_EN defined: zero port present, registered with result (updated on the same edge), reset value 1.
- Not defined: zero port and its register are absent; all other behaviour identical.

## Structure
- Package logic_unit_pkg: op encoding typedef (OP_NOT, OP_AND, OP_OR, OP_XOR) and the FSM state typedef.
- Sub-module logic_slice: combinational SLICE-bit op applied to two SLICE-bit inputs, instantiated once in the datapath.
- Elaboration check: WIDTH % SLICE == 0 and SLICE ≥ 1.

## Test plan
- Defaults, op=NOT, a=1111_1111 → after 4 cycles done=1, result=0000_0000, zero=1 (flags on).
- op=NOT a=0000_0000, then a=1001_1001, then a=1111_0000 → results 1111_1111, 0110_0110, 0000_1111; zero=0 each time.
- op=AND a=1100_1010 b=1010_0110 → 1000_0010; op=OR → 1110_1110; op=XOR → 0110_1100.
- Start accepted, a/b/op changed and start pulsed during BUSY → result matches the originally latched operands, only one done pulse.
- start held high, three operations → done pulses 5 cycles apart, busy never overlaps done.
- reset asserted on the 2nd BUSY cycle → next edge busy=0, done=0, result=0; no done follows; new start afterwards completes normally in 4 cycles.
